// File: rtl/adc_par_rd_ctrl.sv
// Parallel-bus ADC controller: config write, simultaneous conversion, BUSY handshake,
// sequential channel readback with auto-sampling, BUSY timeouts and overrun flagging.
module adc_par_rd_ctrl #(
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned WR_LOW_CYC   = 2,
  parameter int unsigned RD_LOW_CYC   = 3,
  parameter int unsigned RD_HIGH_CYC  = 2,
  parameter int unsigned CONVST_CYC   = 2,
  parameter int unsigned BUSY_RISE_TO = 16,
  parameter int unsigned CONV_TO      = 200,
  parameter int unsigned PERIOD_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_req,
  input  logic [31:0]           cfg_word,
  input  logic                  start,
  input  logic                  auto_en,
  input  logic [PERIOD_W-1:0]   sample_period,
  output logic                  CS_N,
  output logic                  WR_N,
  output logic                  RD_N,
  output logic [NUM_CH/2-1:0]   CONVST,
  input  logic                  BUSY,
  input  logic [DATA_W-1:0]     db_in,
  output logic [DATA_W-1:0]     db_out,
  output logic                  db_oe,
  output logic [DATA_W-1:0]     sample_data,
  output logic [2:0]            sample_ch,
  output logic                  sample_valid,
  output logic                  frame_done,
  output logic                  idle,
  output logic                  timeout_err,
  output logic                  overrun_err
);

  localparam int unsigned NCV    = NUM_CH / 2;
  localparam int unsigned PH_M0  = (WR_LOW_CYC > RD_LOW_CYC) ? WR_LOW_CYC : RD_LOW_CYC;
  localparam int unsigned PH_M1  = (RD_HIGH_CYC > CONVST_CYC) ? RD_HIGH_CYC : CONVST_CYC;
  localparam int unsigned PH_MAX = (PH_M0 > PH_M1) ? PH_M0 : PH_M1;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam int unsigned TO_MAX = (BUSY_RISE_TO > CONV_TO) ? BUSY_RISE_TO : CONV_TO;
  localparam int unsigned TO_W   = $clog2(TO_MAX + 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CFG_SETUP = 4'd1;
  localparam logic [3:0] S_CFG_WR    = 4'd2;
  localparam logic [3:0] S_CFG_GAP   = 4'd3;
  localparam logic [3:0] S_CONV      = 4'd4;
  localparam logic [3:0] S_WAIT_BH   = 4'd5;
  localparam logic [3:0] S_WAIT_BL   = 4'd6;
  localparam logic [3:0] S_RD_SETUP  = 4'd7;
  localparam logic [3:0] S_RD_LO     = 4'd8;
  localparam logic [3:0] S_RD_HI     = 4'd9;
  localparam logic [3:0] S_DONE      = 4'd10;

  logic [3:0]          state, state_d;
  logic [PH_W-1:0]     cnt, cnt_d;
  logic [TO_W-1:0]     tcnt, tcnt_d;
  logic [2:0]          ch, ch_d;
  logic                word_sel, word_sel_d;
  logic [15:0]         cfg_lo, cfg_lo_d;
  logic [PERIOD_W-1:0] per_cnt, per_cnt_d;
  logic                busy_m, busy_s;
  logic                convst_q, convst_d;
  logic                cs_n_d, wr_n_d, rd_n_d, db_oe_d;
  logic [DATA_W-1:0]   db_out_d, sample_data_d;
  logic [2:0]          sample_ch_d;
  logic                sample_valid_d, frame_done_d, idle_d, timeout_d, overrun_d;
  logic [PERIOD_W-1:0] per_last;
  logic                auto_hit;

  assign CONVST   = {NCV{convst_q}};
  assign per_last = (sample_period == '0) ? '0 : sample_period - 1'b1;
  assign auto_hit = auto_en && (per_cnt >= per_last);

  // BUSY synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m <= 1'b0;
      busy_s <= 1'b0;
    end else begin
      busy_m <= BUSY;
      busy_s <= busy_m;
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      tcnt         <= '0;
      ch           <= '0;
      word_sel     <= 1'b0;
      cfg_lo       <= '0;
      per_cnt      <= '0;
      convst_q     <= 1'b0;
      CS_N         <= 1'b1;
      WR_N         <= 1'b1;
      RD_N         <= 1'b1;
      db_oe        <= 1'b0;
      db_out       <= '0;
      sample_data  <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
      idle         <= 1'b1;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      tcnt         <= tcnt_d;
      ch           <= ch_d;
      word_sel     <= word_sel_d;
      cfg_lo       <= cfg_lo_d;
      per_cnt      <= per_cnt_d;
      convst_q     <= convst_d;
      CS_N         <= cs_n_d;
      WR_N         <= wr_n_d;
      RD_N         <= rd_n_d;
      db_oe        <= db_oe_d;
      db_out       <= db_out_d;
      sample_data  <= sample_data_d;
      sample_ch    <= sample_ch_d;
      sample_valid <= sample_valid_d;
      frame_done   <= frame_done_d;
      idle         <= idle_d;
      timeout_err  <= timeout_d;
      overrun_err  <= overrun_d;
    end
  end

  // next state and next output values
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    tcnt_d         = tcnt;
    ch_d           = ch;
    word_sel_d     = word_sel;
    cfg_lo_d       = cfg_lo;
    per_cnt_d      = (per_cnt == '1) ? per_cnt : per_cnt + 1'b1;
    convst_d       = convst_q;
    cs_n_d         = CS_N;
    wr_n_d         = WR_N;
    rd_n_d         = RD_N;
    db_oe_d        = db_oe;
    db_out_d       = db_out;
    sample_data_d  = sample_data;
    sample_ch_d    = sample_ch;
    sample_valid_d = 1'b0;
    frame_done_d   = 1'b0;
    timeout_d      = timeout_err;
    overrun_d      = overrun_err | (auto_hit && (state != S_IDLE));

    case (state)
      S_IDLE: begin
        if (cfg_req) begin
          state_d    = S_CFG_SETUP;
          cfg_lo_d   = cfg_word[15:0];
          word_sel_d = 1'b0;
          timeout_d  = 1'b0;
          cs_n_d     = 1'b0;
          db_oe_d    = 1'b1;
          db_out_d   = DATA_W'(cfg_word[31:16]);
        end else if (start || auto_hit) begin
          state_d   = S_CONV;
          cnt_d     = '0;
          tcnt_d    = '0;
          ch_d      = '0;
          per_cnt_d = '0;
          convst_d  = 1'b1;
          if (start) timeout_d = 1'b0;
        end
      end
      S_CFG_SETUP: begin
        state_d = S_CFG_WR;
        cnt_d   = '0;
        wr_n_d  = 1'b0;
      end
      S_CFG_WR: begin
        if (cnt == PH_W'(WR_LOW_CYC - 1)) begin
          state_d = S_CFG_GAP;
          wr_n_d  = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_CFG_GAP: begin
        if (!word_sel) begin
          state_d    = S_CFG_SETUP;
          word_sel_d = 1'b1;
          db_out_d   = DATA_W'(cfg_lo);
        end else begin
          state_d = S_IDLE;
          cs_n_d  = 1'b1;
          db_oe_d = 1'b0;
        end
      end
      S_CONV: begin
        tcnt_d = tcnt + 1'b1;
        if (cnt == PH_W'(CONVST_CYC - 1)) begin
          state_d  = S_WAIT_BH;
          convst_d = 1'b0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_WAIT_BH: begin
        if (busy_s) begin
          state_d = S_WAIT_BL;
          tcnt_d  = '0;
        end else if (tcnt >= TO_W'(BUSY_RISE_TO - 1)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          convst_d  = 1'b0;
          cs_n_d    = 1'b1;
        end else begin
          tcnt_d = tcnt + 1'b1;
        end
      end
      S_WAIT_BL: begin
        if (!busy_s) begin
          state_d = S_RD_SETUP;
          cs_n_d  = 1'b0;
        end else if (tcnt >= TO_W'(CONV_TO - 1)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          convst_d  = 1'b0;
          cs_n_d    = 1'b1;
        end else begin
          tcnt_d = tcnt + 1'b1;
        end
      end
      S_RD_SETUP: begin
        state_d = S_RD_LO;
        cnt_d   = '0;
        rd_n_d  = 1'b0;
      end
      S_RD_LO: begin
        if (cnt == PH_W'(RD_LOW_CYC - 1)) begin
          sample_data_d  = db_in;
          sample_ch_d    = ch;
          sample_valid_d = 1'b1;
          rd_n_d         = 1'b1;
          cnt_d          = '0;
          if (ch == 3'(NUM_CH - 1)) begin
            state_d      = S_DONE;
            cs_n_d       = 1'b1;
            frame_done_d = 1'b1;
          end else begin
            state_d = S_RD_HI;
            ch_d    = ch + 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_RD_HI: begin
        if (cnt == PH_W'(RD_HIGH_CYC - 1)) begin
          state_d = S_RD_LO;
          cnt_d   = '0;
          rd_n_d  = 1'b0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    idle_d = (state_d == S_IDLE);
  end

endmodule

// File: doc/adc_par_rd_ctrl.md
Name: adc_par_rd_ctrl

Overview:
Synthesizable controller for the team's ADS8528-class parallel-bus ADC, parametrised in channel count, data width and bus timing. It writes the 32-bit configuration word as two bus words, launches simultaneous conversions, waits on BUSY and reads back NUM_CH results as a streamed sample interface. It adds free-running auto-sampling, BUSY timeouts and overrun detection. It sits between the ADC pins (or the ADC behavioural model in simulation) and the sound-localization sample pipeline.

Parameters:
NUM_CH, 8, channels read per frame (2..8, even); CONVST pins = NUM_CH/2
DATA_W, 16, ADC bus/data width
WR_LOW_CYC, 2, clk cycles WR_N held low per config word (>=1)
RD_LOW_CYC, 3, clk cycles RD_N held low per read (>=2)
RD_HIGH_CYC, 2, clk cycles RD_N high between reads (>=1)
CONVST_CYC, 2, clk cycles CONVST held high (>=1)
BUSY_RISE_TO, 16, max cycles from CONVST rise to synced BUSY high
CONV_TO, 200, max cycles synced BUSY may stay high
PERIOD_W, 16, width of sample_period

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_req  in  1  pulse: write cfg_word to ADC (accepted only in IDLE)
cfg_word  in  32  config word; [31:16] written first
start  in  1  pulse: one conversion+read frame (accepted only in IDLE)
auto_en  in  1  level: free-running frames every sample_period cycles
sample_period  in  PERIOD_W  cycles between CONVST rising edges in auto mode
CS_N  out  1  ADC chip select
WR_N  out  1  ADC write strobe
RD_N  out  1  ADC read strobe
CONVST  out  NUM_CH/2  conversion start, all bits driven identically
BUSY  in  1  ADC busy (asynchronous)
db_in  in  DATA_W  bus read data
db_out  out  DATA_W  bus write data
db_oe  out  1  bus output enable (high only while writing)
sample_data  out  DATA_W  read result
sample_ch  out  3  channel index 0..NUM_CH-1 of sample_data
sample_valid  out  1  one-cycle strobe
frame_done  out  1  one-cycle strobe after last sample
idle  out  1  FSM in IDLE
timeout_err  out  1  sticky BUSY timeout
overrun_err  out  1  sticky auto-mode overrun

Behaviour:
- Reset (async assert, sync deassert): CS_N=WR_N=RD_N=1, CONVST=0, db_oe=0, db_out=0, sample_*=0, frame_done=0, idle=1, errors=0, counters=0. Reset mid-frame aborts immediately; no partial strobes.
- BUSY passes a 2-flop synchroniser (busy_s); all BUSY decisions use busy_s.
- States: IDLE, CFG_SETUP, CFG_WR, CFG_GAP, CONV, WAIT_BH, WAIT_BL, RD_SETUP, RD_LO, RD_HI, DONE.
- IDLE priority: cfg_req > start > auto trigger. A lower-priority request arriving in the same cycle is dropped, not queued. Requests outside IDLE are ignored.
- Config: CFG_SETUP (1 cycle) drives CS_N=0, db_oe=1, db_out=cfg_word[31:16]. CFG_WR holds WR_N=0 for WR_LOW_CYC cycles. CFG_GAP (1 cycle) drives WR_N=1. The second word repeats with [15:0]. Then CS_N=1, db_oe=0 and the FSM returns to IDLE. cfg_word is latched on accept.
- Frame: CONV drives CONVST high from the cycle after accept for CONVST_CYC cycles. WAIT_BH waits for busy_s=1, timing out after BUSY_RISE_TO cycles counted from CONVST rise. WAIT_BL waits for busy_s=0, timing out after CONV_TO cycles.
- Read: RD_SETUP drives CS_N=0 for 1 cycle. RD_LO holds RD_N=0 for RD_LOW_CYC cycles, and db_in is captured on the last low cycle. RD_HI drives RD_N=1 for RD_HIGH_CYC cycles. The cycle after capture: sample_valid=1 with sample_data and sample_ch=k. Repeat for k=0..NUM_CH-1; the final RD_HI is skipped. DONE drives CS_N=1 and frame_done=1 for 1 cycle, then returns to IDLE.
- Timeout: set timeout_err, drive CONVST=0 and CS_N=1, return to IDLE, no frame_done. timeout_err clears when the next start or cfg_req is accepted.
- Auto: a period counter restarts at each CONVST rise. When it reaches sample_period-1 with auto_en=1, a frame triggers. If the FSM is not in IDLE at that point, overrun_err is set and the frame starts on the next IDLE entry. sample_period=0 is treated as 1. Deasserting auto_en finishes the current frame, then stops.
- The FSM never drives WR_N=0 and RD_N=0 together. db_oe=0 whenever RD_N=0.

Test Plan:
- Config: cfg_req, cfg_word=32'hA5A5_0F0F. Expect db_out=16'hA5A5 with WR_N low 2 cycles, gap, then 16'h0F0F with WR_N low 2 cycles. CS_N low throughout both words; idle=1 after.
- Single frame: start, BUSY high 5 cycles after CONVST rise for 40 cycles, db_in returns 16'h1000+k per read. Expect 8 sample_valid strobes, ch 0..7, data 16'h1000..16'h1007, each 5 cycles apart, then one frame_done.
- Timeout: start with BUSY held low. Expect timeout_err at 16 cycles after CONVST rise, CS_N=1, no sample_valid; the next start clears timeout_err.
- Auto/overrun: auto_en=1, sample_period=100. Expect CONVST rises exactly 100 cycles apart. With sample_period=20, expect overrun_err=1 and back-to-back frames.
- Priority/reset: cfg_req+start in the same cycle. Expect only the config write; the start is dropped. Assert rst_n low during the 4th read: all outputs at reset values immediately, and no sample_valid after deassert.
- NUM_CH=2 build: expect 2 samples per frame and a 1-bit-wide CONVST.
